// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXEC/MEM/WB
// over a shared req/ready memory port, with illegal-opcode and bus-timeout trapping.
module multicycle_sequencer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       iord,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_src,
  output logic       alusrc,
  output logic [1:0] aluop,
  output logic       regwrite,
  output logic [1:0] wb_sel,
  output logic       retire,
  output logic [1:0] err,
  output logic [2:0] state
);

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_ILL} cls_t;

  state_t        r_state, w_next;
  cls_t          r_cls, w_cls;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [1:0]    r_err, w_err_next;
  logic          w_timeout;

  always_comb begin
    case (opcode)
      7'b0110011: w_cls = C_R;
      7'b0010011: w_cls = C_I;
      7'b0000011: w_cls = C_LW;
      7'b0100011: w_cls = C_SW;
      7'b1100011: w_cls = C_BEQ;
      7'b1101111: w_cls = C_JAL;
      default:    w_cls = C_ILL;
    endcase
  end

  // Last stalled cycle before the limit; a ready in that same cycle still completes.
  assign w_timeout = !mem_ready && (r_cnt == CW'(TIMEOUT_CYC - 1));

  // NOTE: every output and next-state term gets a default before the case, so no
  // path through the block leaves a signal unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_err_next = r_err;
    w_cnt_next = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alusrc     = 1'b0;
    aluop      = 2'b00;
    regwrite   = 1'b0;
    wb_sel     = 2'b00;
    retire     = 1'b0;
    case (r_state)
      S_IDLE: w_next = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          w_next = S_DECODE;
        end else if (w_timeout) begin
          w_next     = S_HALT;
          w_err_next = 2'b10;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_DECODE: begin
        if (w_cls == C_ILL) begin
          w_next     = S_HALT;
          w_err_next = 2'b01;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        case (r_cls)
          C_R:  begin aluop = 2'b10; w_next = S_WB; end
          C_I:  begin alusrc = 1'b1; aluop = 2'b10; w_next = S_WB; end
          C_LW, C_SW: begin alusrc = 1'b1; w_next = S_MEM; end
          C_BEQ: begin
            aluop  = 2'b01;
            pc_src = 2'b01;
            pc_we  = zero;
            retire = 1'b1;
            w_next = S_FETCH;
          end
          C_JAL: begin
            regwrite = 1'b1;
            wb_sel   = 2'b10;
            pc_we    = 1'b1;
            pc_src   = 2'b10;
            retire   = 1'b1;
            w_next   = S_FETCH;
          end
          default: w_next = S_HALT;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        alusrc  = 1'b1;
        mem_we  = (r_cls == C_SW);
        if (mem_ready) begin
          retire = (r_cls == C_SW);
          w_next = (r_cls == C_SW) ? S_FETCH : S_WB;
        end else if (w_timeout) begin
          w_next     = S_HALT;
          w_err_next = 2'b10;
        end else begin
          w_cnt_next = r_cnt + CW'(1);
        end
      end
      S_WB: begin
        regwrite = 1'b1;
        retire   = 1'b1;
        w_next   = S_FETCH;
        if (r_cls == C_LW) begin
          wb_sel = 2'b01;
        end else begin
          alusrc = (r_cls == C_I);
          aluop  = 2'b10;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_err_next;
    end
  end

  // NOTE: the opcode class is only read after DECODE has loaded it, so it has no reset.
  always_ff @(posedge clk) begin
    if (r_state == S_DECODE) r_cls <= w_cls;
  end

  assign err   = r_err;
  assign state = r_state;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: stimulus pushes the expected per-cycle control
// word into a scoreboard queue, and a negedge monitor pops and compares the DUT outputs.
module tb_multicycle_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, iord, ir_we, pc_we, alusrc, regwrite, retire;
  logic [1:0] pc_src, aluop, wb_sel, err;
  logic [2:0] state;

  typedef struct packed {
    logic [2:0] st;
    logic       req, we, iord, irwe, pcwe;
    logic [1:0] pcsrc;
    logic       asrc;
    logic [1:0] aop;
    logic       rw;
    logic [1:0] wbs;
    logic       ret;
    logic [1:0] err;
  } ctl_t;

  typedef struct {
    string name;
    ctl_t  exp;
  } item_t;

  item_t sb[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  multicycle_sequencer #(.TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we), .pc_we(pc_we),
    .pc_src(pc_src), .alusrc(alusrc), .aluop(aluop), .regwrite(regwrite),
    .wb_sel(wb_sel), .retire(retire), .err(err), .state(state)
  );

  always #5 clk = ~clk;

  // Argument order: state req we iord ir_we pc_we pc_src alusrc aluop regwrite wb_sel retire err
  function automatic ctl_t mk(input logic [2:0] st, input logic req, we, io, irw, pcw,
                              input logic [1:0] pcs, input logic as, input logic [1:0] ao,
                              input logic rw, input logic [1:0] wbs, input logic ret,
                              input logic [1:0] e);
    return {st, req, we, io, irw, pcw, pcs, as, ao, rw, wbs, ret, e};
  endfunction

  // Inputs for one cycle are driven just after the rising edge; the expected outputs
  // for that cycle are queued at the same time.
  task automatic step(input string nm, input ctl_t e, input logic rdy, input logic z,
                      input logic rn);
    item_t it;
    rst_n     = rn;
    mem_ready = rdy;
    zero      = z;
    it.name   = nm;
    it.exp    = e;
    sb.push_back(it);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      item_t it;
      ctl_t  act;
      it  = sb.pop_front();
      act = {state, mem_req, mem_we, iord, ir_we, pc_we, pc_src, alusrc, aluop,
             regwrite, wb_sel, retire, err};
      n_checks++;
      if (act !== it.exp) begin
        n_fail++;
        $display("FAIL %s: got %h (state %0d) expected %h (state %0d) at %0t",
                 it.name, act, act.st, it.exp, it.exp.st, $time);
      end
    end
  end

  initial begin
    rst_n = 1'b0; opcode = 7'b0110011; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk); #1;

    // Reset and release, then zero-wait R-type.
    step("rst_idle",   mk(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 0);
    step("rel_idle",   mk(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("r_fetch",    mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("r_decode",   mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("r_exec",     mk(3,0,0,0,0,0,2'b00,0,2'b10,0,2'b00,0,2'b00), 1, 0, 1);
    step("r_wb",       mk(5,0,0,0,0,0,2'b00,0,2'b10,1,2'b00,1,2'b00), 0, 0, 1);

    // LW with ready delayed 3 cycles in MEM: 8 cycles total.
    opcode = 7'b0000011;
    step("lw_fetch",   mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("lw_decode",  mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("lw_exec",    mk(3,0,0,0,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("lw_mem_wait", mk(4,1,0,1,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("lw_mem_rdy", mk(4,1,0,1,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("lw_wb",      mk(5,0,0,0,0,0,2'b00,0,2'b00,1,2'b01,1,2'b00), 0, 0, 1);

    // BEQ taken, then not taken.
    opcode = 7'b1100011;
    step("beq1_fetch", mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("beq1_dec",   mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("beq1_exec",  mk(3,0,0,0,0,1,2'b01,0,2'b01,0,2'b00,1,2'b00), 0, 1, 1);
    step("beq0_fetch", mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("beq0_dec",   mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("beq0_exec",  mk(3,0,0,0,0,0,2'b01,0,2'b01,0,2'b00,1,2'b00), 0, 0, 1);

    // I-ALU with two fetch wait states.
    opcode = 7'b0010011;
    step("i_fetch_w",  mk(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("i_fetch_w",  mk(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("i_fetch",    mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("i_decode",   mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("i_exec",     mk(3,0,0,0,0,0,2'b00,1,2'b10,0,2'b00,0,2'b00), 0, 0, 1);
    step("i_wb",       mk(5,0,0,0,0,0,2'b00,1,2'b10,1,2'b00,1,2'b00), 0, 0, 1);

    // Zero-wait SW retires from MEM.
    opcode = 7'b0100011;
    step("sw_fetch",   mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("sw_decode",  mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("sw_exec",    mk(3,0,0,0,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("sw_mem",     mk(4,1,1,1,0,0,2'b00,1,2'b00,0,2'b00,1,2'b00), 1, 0, 1);

    // JAL.
    opcode = 7'b1101111;
    step("jal_fetch",  mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("jal_decode", mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("jal_exec",   mk(3,0,0,0,0,1,2'b10,0,2'b00,1,2'b10,1,2'b00), 0, 0, 1);

    // Ready arriving on the 16th stalled fetch cycle wins over the timeout.
    opcode = 7'b0110011;
    for (int i = 0; i < 15; i++)
      step("edge_fetch_w", mk(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("edge_fetch", mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("edge_dec",   mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("edge_exec",  mk(3,0,0,0,0,0,2'b00,0,2'b10,0,2'b00,0,2'b00), 0, 0, 1);
    step("edge_wb",    mk(5,0,0,0,0,0,2'b00,0,2'b10,1,2'b00,1,2'b00), 0, 0, 1);

    // SW interrupted by reset during the MEM stall.
    opcode = 7'b0100011;
    step("swr_fetch",  mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("swr_decode", mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("swr_exec",   mk(3,0,0,0,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("swr_mem_w",  mk(4,1,1,1,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("swr_mem_w",  mk(4,1,1,1,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("swr_mem_rst", mk(4,1,1,1,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 0);
    step("swr_idle",   mk(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);

    // Fetch timeout: 16 stalled cycles, then HALT with err=10 and ready ignored.
    for (int i = 0; i < 16; i++)
      step("to_fetch_w", mk(1,1,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    for (int i = 0; i < 3; i++)
      step("to_halt",    mk(7,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b10), 1, 0, 1);
    step("to_halt_rst", mk(7,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b10), 0, 0, 0);
    step("to_idle",    mk(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);

    // Illegal opcode: HALT with err=01, no further requests.
    opcode = 7'b1110011;
    step("ill_fetch",  mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("ill_decode", mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    for (int i = 0; i < 3; i++)
      step("ill_halt",   mk(7,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b01), 1, 1, 1);
    step("ill_halt_rst", mk(7,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b01), 0, 0, 0);
    step("ill_idle",   mk(0,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);

    // LW data-phase timeout.
    opcode = 7'b0000011;
    step("lwt_fetch",  mk(1,1,0,0,1,1,2'b00,0,2'b00,0,2'b00,0,2'b00), 1, 0, 1);
    step("lwt_decode", mk(2,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    step("lwt_exec",   mk(3,0,0,0,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    for (int i = 0; i < 16; i++)
      step("lwt_mem_w",  mk(4,1,0,1,0,0,2'b00,1,2'b00,0,2'b00,0,2'b00), 0, 0, 1);
    for (int i = 0; i < 2; i++)
      step("lwt_halt",   mk(7,0,0,0,0,0,2'b00,0,2'b00,0,2'b00,0,2'b10), 1, 0, 1);

    @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
